// File: rtl/counter_run_arbiter_if.sv
// -----------------------------------------------------------------------------
// counter_run_arbiter_if
// Requester-side bundle of the counter run arbiter.
//   req     : per-requester request level            (requesters -> arbiter)
//   run_len : packed target lengths, slice i = run_len[i*CNT_W +: CNT_W]
//   gnt     : one-hot grant, zero when idle           (arbiter -> requesters)
//   done    : one-cycle one-hot completion pulse      (arbiter -> requesters)
//   busy    : arbiter is not idle                     (arbiter -> requesters)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface counter_run_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*CNT_W-1:0] run_len;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;

   modport master (
      output req,
      output run_len,
      input  gnt,
      input  done,
      input  busy
   );

   modport slave (
      input  req,
      input  run_len,
      output gnt,
      output done,
      output busy
   );
endinterface

// File: rtl/counter_run_arbiter.sv
// -----------------------------------------------------------------------------
// counter_run_arbiter
// Round-robin sharing of one external enable/reset up-counter among NUM_REQ
// requesters. A granted requester gets a clean run: the counter is cleared,
// enabled until it equals the requester's latched length, then done pulses
// and the pointer moves past the requester.
//
// Ports
//   clk_i        : sole clock, rising edge
//   reset_i      : synchronous active-high reset (also clears the counter)
//   bus          : counter_run_arbiter_if.slave (req, run_len, gnt, done, busy)
//   cnt_value_i  : count output of the shared counter
//   cnt_enable_o : drives the counter's enable
//   cnt_reset_o  : drives the counter's reset
//
// Optional feature macro: CNT_ARB_ABORT_EN
//   defined     : dropping req of the granted requester during RUN aborts the
//                 run (no done, pointer advances past it)
//   not defined : a granted run always completes
// -----------------------------------------------------------------------------
module counter_run_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   counter_run_arbiter_if.slave bus,
   input  logic [CNT_W-1:0]     cnt_value_i,
   output logic                 cnt_enable_o,
   output logic                 cnt_reset_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   len_q, len_d;

   logic               pick_vld_s;
   logic [IDX_W-1:0]   pick_idx_s;
   int                 cand_s;
   logic               hit_s;
   logic [IDX_W-1:0]   idx_inc_s;
   logic               cnt_match_s;
   logic               abort_s;
   logic [NUM_REQ-1:0] idx_onehot_s;

   // Cyclic first-set search starting at ptr_q. Offsets are walked from the
   // far end back toward ptr_q so the smallest offset overwrites last and wins.
   always_comb begin
      pick_vld_s = 1'b0;
      pick_idx_s = ptr_q;
      cand_s     = 0;
      hit_s      = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand_s     = (int'(ptr_q) + off) % NUM_REQ;
         hit_s      = bus.req[cand_s];
         pick_idx_s = hit_s ? IDX_W'(cand_s) : pick_idx_s;
         pick_vld_s = pick_vld_s | hit_s;
      end
   end

   // Pointer successor of the granted index, wrapping at NUM_REQ.
   assign idx_inc_s   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
   assign cnt_match_s = (cnt_value_i == len_q);

`ifdef CNT_ARB_ABORT_EN
   assign abort_s = ~bus.req[idx_q];
`else
   assign abort_s = 1'b0;
`endif

   // Next-state, pointer and latch logic of the grant FSM.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld_s) begin
               state_d = ST_CLEAR;
               idx_d   = pick_idx_s;
               len_d   = bus.run_len[int'(pick_idx_s)*CNT_W +: CNT_W];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // Abort wins over a same-cycle length match: no done is owed.
            if (abort_s) begin
               state_d = ST_IDLE;
               ptr_d   = idx_inc_s;
            end else if (cnt_match_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = idx_inc_s;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-grant registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
      end
   end

   // Outputs decode registered state; only cnt_enable also looks at the
   // counter value (and the owner's req when aborts are enabled).
   assign idx_onehot_s = NUM_REQ'(1) << idx_q;
   assign bus.gnt      = (state_q != ST_IDLE) ? idx_onehot_s : '0;
   assign bus.done     = (state_q == ST_DONE) ? idx_onehot_s : '0;
   assign bus.busy     = (state_q != ST_IDLE);

   // reset_i feeds cnt_reset directly so the counter clears on the same edge
   // as the FSM; enable is masked during reset to keep the pins unambiguous.
   assign cnt_reset_o  = reset_i | (state_q == ST_CLEAR);
   assign cnt_enable_o = ~reset_i & (state_q == ST_RUN) & ~cnt_match_s & ~abort_s;

endmodule
